// File: rtl/count2_monitor.sv
// Receive-side checker for the 2-bit skip counter: tracks lock to the
// 00->(01)->10->11 sequence, recovers x, and keeps lap/error statistics.
module count2_monitor #(
  parameter int LAP_W = 8,
  parameter int ERR_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [1:0]       count_in,
  output logic             sync,
  output logic             x_rec,
  output logic             x_valid,
  output logic             lap_done,
  output logic             err,
  output logic [LAP_W-1:0] lap_cnt,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic {HUNT, LOCK} state_t;

  state_t           state, state_n;
  logic [1:0]       prev_q, prev_q_n;
  logic             x_rec_n, x_valid_n, lap_done_n, err_n;
  logic [LAP_W-1:0] lap_cnt_n;
  logic [ERR_W-1:0] err_cnt_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= HUNT;
      prev_q   <= 2'b00;
      sync     <= 1'b0;
      x_rec    <= 1'b0;
      x_valid  <= 1'b0;
      lap_done <= 1'b0;
      err      <= 1'b0;
      lap_cnt  <= '0;
      err_cnt  <= '0;
    end else begin
      state    <= state_n;
      prev_q   <= prev_q_n;
      sync     <= (state_n == LOCK);
      x_rec    <= x_rec_n;
      x_valid  <= x_valid_n;
      lap_done <= lap_done_n;
      err      <= err_n;
      lap_cnt  <= lap_cnt_n;
      err_cnt  <= err_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    prev_q_n   = prev_q;
    x_rec_n    = x_rec;
    x_valid_n  = 1'b0;
    lap_done_n = 1'b0;
    err_n      = 1'b0;
    lap_cnt_n  = lap_cnt;
    err_cnt_n  = err_cnt;

    if (en) begin
      unique case (state)
        HUNT: begin
          if (count_in == 2'b00) begin
            state_n  = LOCK;
            prev_q_n = 2'b00;
          end
        end
        LOCK: begin
          prev_q_n = count_in;
          case ({prev_q, count_in})
            4'b0001: begin
              x_rec_n   = 1'b0;
              x_valid_n = 1'b1;
            end
            4'b0010: begin
              x_rec_n   = 1'b1;
              x_valid_n = 1'b1;
            end
            4'b0110, 4'b1011: ;
            4'b1100: begin
              lap_done_n = 1'b1;
              lap_cnt_n  = lap_cnt + LAP_W'(1);
            end
            default: begin
              // The offending sample is discarded; relock waits for a fresh 00.
              err_n   = 1'b1;
              state_n = HUNT;
              if (err_cnt != '1) err_cnt_n = err_cnt + ERR_W'(1);
            end
          endcase
        end
        default: state_n = HUNT;
      endcase
    end
  end

endmodule

// File: doc/count2_monitor.md
Name: count2_monitor

Overview:
- Receive-side checker for the 2-bit skip counter: samples the counter's `count` bus each enabled clock.
- Recovers the `x` decision made at each 00 state, i.e. whether the sequence went 00->01 (x=0) or 00->10 (x=1).
- Flags illegal transitions and keeps lap and error statistics.
- Sits on the same clock as the counter, downstream of it, feeding status logic.

Parameters:
- LAP_W, 8, width of lap counter (wraps).
- ERR_W, 4, width of error counter (saturates).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- en  input  1  sample enable; count_in evaluated only when 1.
- count_in  input  2  counter value under observation.
- sync  output  1  1 while monitor is locked to the sequence.
- x_rec  output  1  recovered x from most recent 00 exit.
- x_valid  output  1  one-cycle pulse when x_rec updated.
- lap_done  output  1  one-cycle pulse on legal 11->00.
- err  output  1  one-cycle pulse on illegal transition.
- lap_cnt  output  LAP_W  completed laps since reset, wraps.
- err_cnt  output  ERR_W  illegal transitions since reset, saturates at all-ones.

Behaviour:
- Reset (reset_n=0, async):
  - state=HUNT, prev_q=00.
  - sync=0, x_rec=0, x_valid=0, lap_done=0, err=0, lap_cnt=0, err_cnt=0.
  - Reset mid-operation discards all history; the monitor re-enters HUNT.
- Registers update only on rising clk. All outputs are registered; a pulse is high for exactly the cycle after the sampling edge.
- en=0: no state, prev_q or counter change; pulses deassert.
- States:
  - HUNT: sync=0. An enabled sample of 00 moves to LOCK with prev_q=00. Any other sample stays in HUNT with no err.
  - LOCK: sync=1. Each enabled sample is compared with prev_q, then prev_q<=count_in.
- Legal transitions in LOCK:
  - 00->01: x_rec<=0, x_valid=1.
  - 00->10: x_rec<=1, x_valid=1.
  - 01->10 and 10->11: no pulse.
  - 11->00: lap_done=1, lap_cnt<=lap_cnt+1, wrapping modulo 2^LAP_W.
- Illegal transitions in LOCK: any other pair, including hold (same value twice), 00->11, 01->11, 01->00, 10->00, etc.
  - err=1; err_cnt+1 unless already all-ones.
  - State goes to HUNT, sync<=0, x_rec unchanged.
  - The illegal sample itself is not reused for relock; the next enabled 00 relocks.
- Simultaneous events: lap_done and err are mutually exclusive. x_valid and lap_done never share a cycle.
- Lap length: with x=0 a lap is 4 enabled samples (00,01,10,11); with x=1 it is 3 (00,10,11).

Test Plan:
- Reset 2 cycles, en=1, feed 00,01,10,11,00 → sync=1 after first edge; x_valid pulse with x_rec=0 after 01 sample; lap_done pulse and lap_cnt=1 after final 00; err never asserted.
- From lock, feed 00,10,11,00,10 → x_rec=1 with x_valid after each 10 following 00; lap_cnt increments by 1; 3 samples per lap.
- Feed 00,01,11 → err pulse after 11, err_cnt=1, sync=0. Then feed 10,00,01 → no further err, sync=1 after 00, x_rec=0 after 01.
- Inject 16 illegal transitions (alternate 00,00 holds with relock) → err_cnt reaches 4'hF and stays 4'hF.
- Mid-lap (after 00,10) toggle en=0 for 3 cycles with count_in changing randomly → no outputs change. Resume en=1 with 11,00 → lap_done, no err.
- Assert reset_n=0 asynchronously between edges while locked with lap_cnt=5 → all outputs 0 immediately. Release; first sample 10 keeps HUNT with no err.
